// File: rtl/axis_circular_reader.sv
// Reads a window out of a circular BRAM capture buffer and streams it out
// over AXI4-Stream, starting at a trigger position and wrapping at the top.
module axis_circular_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_start_addr,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [CNTR_WIDTH-1:0]      CNT_ONE  = 1;
  localparam logic [CNTR_WIDTH-1:0]      CNT_ZERO = '0;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  // Assert immediately, release two clocks later
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0]                 state_q, state_d;
  logic                       start_q, start_d;
  logic                       armed_q, armed_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNTR_WIDTH-1:0]      rem_q, rem_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic start_edge;
  logic tvalid;
  logic fire;

  assign start_edge = start & ~start_q & armed_q;
  assign tvalid     = (state_q == S_STREAM);
  assign fire       = tvalid & m_axis_tready;

  always_comb begin
    state_d = state_q;
    start_d = start;
    armed_d = armed_q | ~start;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          addr_d  = cfg_start_addr;
          rem_d   = cfg_length;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = (cfg_length != CNT_ZERO) ? S_PRIME : S_FINISH;
        end
      end
      S_PRIME: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (fire) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Word on the bus always comes from addr_q; advance only on handshake
  assign bram_porta_addr = fire ? addr_q + ADDR_ONE : addr_q;
  assign bram_porta_clk  = aclk;
  assign bram_porta_rst  = ~aresetn;

  assign m_axis_tvalid = tvalid;
  assign m_axis_tlast  = tvalid & (rem_q == CNT_ONE);
  assign m_axis_tdata  = tvalid ? bram_porta_rddata : '0;

  assign busy = busy_q & (state_q != S_FINISH);
  assign done = done_q | (state_q == S_FINISH);

endmodule

// File: tb/tb_axis_circular_reader.sv
// Scoreboard bench for axis_circular_reader: directed readouts with a
// BRAM model whose word is a fixed pattern of its address.
module tb_axis_circular_reader;

  logic        aclk;
  logic        aresetn;
  logic [15:0] cfg_start_addr;
  logic [15:0] cfg_length;
  logic        start;
  logic        busy;
  logic        done;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        bram_porta_clk;
  logic        bram_porta_rst;
  logic [15:0] bram_porta_addr;
  logic [31:0] bram_porta_rddata;

  axis_circular_reader dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .cfg_start_addr    (cfg_start_addr),
    .cfg_length        (cfg_length),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tlast      (m_axis_tlast),
    .bram_porta_clk    (bram_porta_clk),
    .bram_porta_rst    (bram_porta_rst),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_rddata (bram_porta_rddata)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   beats = 0;
  int   done_rises = 0;
  bit   rdy_mode = 0;

  function automatic logic [31:0] word(input logic [15:0] a);
    return {16'hD000, a};
  endfunction

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Registered-read BRAM: data one cycle after its address
  always @(posedge aclk) bram_porta_rddata <= word(bram_porta_addr);

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #2;
      m_axis_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic l);
    exp_t e;
    e.d = word(a);
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [15:0] a, input int n);
    logic [15:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      push(p, i == n - 1);
      p = p + 16'd1;
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold on stalls
  initial begin
    bit          stall;
    bit          pdone;
    logic [31:0] pd;
    logic        pl;
    exp_t        e;
    stall = 0;
    pdone = 0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall = 0;
      end else begin
        if (stall) begin
          check("hold_valid", 64'(m_axis_tvalid), 64'd1);
          check("hold_data", 64'(m_axis_tdata), 64'(pd));
          check("hold_last", 64'(m_axis_tlast), 64'(pl));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h want none",
                     m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(m_axis_tdata), 64'(e.d));
            check("beat_last", 64'(m_axis_tlast), 64'(e.l));
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        pd = m_axis_tdata;
        pl = m_axis_tlast;
        if (done && !pdone) done_rises++;
      end
      pdone = done;
    end
  end

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!(done && !busy) && k < budget) begin
      @(negedge aclk);
      k++;
    end
    if (k >= budget) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got busy=%0b done=%0b want done", busy,
               done);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] n,
                        input bit retrig);
    int r0;
    int b0;
    r0 = done_rises;
    b0 = beats;
    @(negedge aclk);
    cfg_start_addr = a;
    cfg_length = n;
    start = 1'b1;
    @(negedge aclk);
    check("busy_after_edge", 64'(busy), 64'(n != 0));
    check("done_after_edge", 64'(done), 64'(n == 0));
    @(negedge aclk);
    if (n != 0) check("first_valid", 64'(m_axis_tvalid), 64'd1);
    start = 1'b0;
    cfg_start_addr = ~a;
    cfg_length = n + 16'd5;
    if (retrig) begin
      repeat (2) @(negedge aclk);
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
    end
    wait_done(300);
    check("done_valid_low", 64'(m_axis_tvalid), 64'd0);
    @(negedge aclk);
    check("beat_count", 64'(beats - b0), 64'(n));
    if (n != 0) check("done_once", 64'(done_rises - r0), 64'd1);
    check("done_sticky", 64'(done), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int b_rst;
    aresetn = 1'b0;
    start = 1'b0;
    cfg_start_addr = '0;
    cfg_length = '0;
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("bram_rst", 64'(bram_porta_rst), 64'd1);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    check("bram_rst_rel", 64'(bram_porta_rst), 64'd0);

    // Basic
    push(16'h0010, 1'b0);
    push(16'h0011, 1'b0);
    push(16'h0012, 1'b0);
    push(16'h0013, 1'b1);
    launch(16'h0010, 16'd4, 1'b0);

    // Wrap past all-ones
    push(16'hFFFE, 1'b0);
    push(16'hFFFF, 1'b0);
    push(16'h0000, 1'b0);
    push(16'h0001, 1'b1);
    launch(16'hFFFE, 16'd4, 1'b0);

    // Backpressure
    rdy_mode = 1;
    push_seq(16'h2000, 16);
    launch(16'h2000, 16'd16, 1'b0);
    rdy_mode = 0;

    // Zero length
    launch(16'h1234, 16'd0, 1'b0);

    // Ignored start during readout, then a fresh accepted start
    push_seq(16'h0300, 8);
    launch(16'h0300, 16'd8, 1'b1);
    push_seq(16'h0400, 2);
    launch(16'h0400, 16'd2, 1'b0);

    // Reset mid-stream
    push_seq(16'h0100, 8);
    b_rst = beats;
    @(negedge aclk);
    cfg_start_addr = 16'h0100;
    cfg_length = 16'd8;
    start = 1'b1;
    for (int k = 0; k < 40 && beats - b_rst < 3; k++) @(negedge aclk);
    check("pre_rst_beats", 64'(beats - b_rst >= 3), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_done", 64'(done), 64'd0);
    check("async_tdata", 64'(m_axis_tdata), 64'd0);
    exp_q.delete();
    b_rst = beats;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (8) @(negedge aclk);
    check("no_beats_after_rst", 64'(beats - b_rst), 64'd0);
    check("idle_busy_after_rst", 64'(busy), 64'd0);
    check("idle_valid_after_rst", 64'(m_axis_tvalid), 64'd0);
    start = 1'b0;
    push_seq(16'h0500, 3);
    launch(16'h0500, 16'd3, 1'b0);

    repeat (5) @(negedge aclk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_circular_reader.md
AXIS_CIRCULAR_READER -- requirements
Module: axis_circular_reader

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32: stream and BRAM data width.
REQ-002 SHALL have parameter BRAM_ADDR_WIDTH, default 16: circular buffer address width; buffer depth is 2^BRAM_ADDR_WIDTH words.
REQ-003 SHALL have parameter CNTR_WIDTH, default 16: width of the read-length counter.
REQ-004 SHALL have port aclk, input, 1: the single clock for all logic.
REQ-005 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port cfg_start_addr, input, BRAM_ADDR_WIDTH: first word to read; normally the writer's trigger position.
REQ-007 SHALL have port cfg_length, input, CNTR_WIDTH: number of words to read.
REQ-008 SHALL have port start, input, 1: level; a rising edge requests one readout.
REQ-009 SHALL have port busy, output, 1: a readout is in progress.
REQ-010 SHALL have port done, output, 1: sticky readout-complete flag.
REQ-011 SHALL have port m_axis_tready, input, 1: AXI4-Stream master ready.
REQ-012 SHALL have port m_axis_tdata, output, AXIS_TDATA_WIDTH: AXI4-Stream master data.
REQ-013 SHALL have port m_axis_tvalid, output, 1: AXI4-Stream master valid.
REQ-014 SHALL have port m_axis_tlast, output, 1: AXI4-Stream master last.
REQ-015 SHALL have port bram_porta_clk, output, 1: BRAM clock, equal to aclk.
REQ-016 SHALL have port bram_porta_rst, output, 1: BRAM reset, equal to ~aresetn.
REQ-017 SHALL have port bram_porta_addr, output, BRAM_ADDR_WIDTH: BRAM read address.
REQ-018 SHALL have port bram_porta_rddata, input, AXIS_TDATA_WIDTH: BRAM read data, valid 1 cycle after its address.

Function
REQ-019 SHALL implement states IDLE, PRIME, STREAM and FINISH.
REQ-020 In IDLE, a start edge (start=1 and registered start=0) SHALL latch cfg_start_addr and cfg_length, clear done, and set busy.
- If the latched length is nonzero: go to PRIME.
- Otherwise: go to FINISH.
REQ-021 PRIME SHALL present the latched start address for one cycle to absorb BRAM latency, then go to STREAM.
REQ-022 Address arithmetic SHALL be modulo 2^BRAM_ADDR_WIDTH; the address after all-ones is zero, with no error flag.
REQ-023 STREAM SHALL emit exactly the latched length of words, in order, from consecutive addresses starting at the latched start address.
REQ-024 The first tvalid SHALL assert no later than 2 cycles after the cycle in which the start edge is sampled.
REQ-025 With m_axis_tready held high, STREAM SHALL sustain one beat per cycle with no bubbles.
REQ-026 Under backpressure (tvalid=1 and tready=0), tdata, tvalid and tlast SHALL hold stable, and no word SHALL be lost or duplicated.
- Implementation: hold the BRAM address, or use an output skid register.
REQ-027 tlast SHALL assert only on the beat whose ordinal equals the latched length.
REQ-028 After the handshake of the last beat, tvalid SHALL deassert in the next cycle and the state SHALL move to FINISH.
REQ-029 FINISH SHALL, in one cycle, set done=1 and busy=0, then return to IDLE.
REQ-030 done SHALL remain 1 until the next accepted start edge or reset.
REQ-031 Start edges while busy=1 SHALL be ignored.
REQ-032 Changes to cfg_start_addr or cfg_length while busy=1 SHALL NOT affect the current readout.
REQ-033 A start level already high when reset deasserts SHALL NOT count as an edge; start must be seen low first.
REQ-034 bram_porta_addr SHALL be don't-care in IDLE and FINISH and SHALL NOT affect the outputs in those states.

Reset
REQ-035 Assertion of aresetn=0 SHALL immediately, without waiting for a clock edge, force the following:
- state to IDLE;
- busy, done, m_axis_tvalid and m_axis_tlast to 0;
- m_axis_tdata to 0;
- internal counters, address and registered start to 0.
REQ-036 Reset asserted mid-STREAM SHALL abandon the readout; after release the block SHALL wait for a fresh start edge.
REQ-037 Reset release SHALL be synchronised so the first active edge is glitch-free.

Verification
REQ-038 Basic: start_addr=0x0010, length=4, tready=1 -> words from addresses 0x0010..0x0013 in order, tlast on beat 4, done=1 one cycle after the last beat.
REQ-039 Wrap: start_addr=0xFFFE, length=4 -> words from addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; tlast on the 0x0001 word.
REQ-040 Backpressure: length=16, tready random at 50% -> exact 16-word sequence; tdata stable on every tvalid=1/tready=0 cycle; exactly one tlast.
REQ-041 Zero length: length=0 -> tvalid never asserts; done=1 within 2 cycles of the start edge.
REQ-042 Ignored start: second start edge during readout of length=8 -> exactly 8 beats, one done; the following start edge in IDLE is accepted.
REQ-043 Reset mid-stream: aresetn low after beat 3 of 8 -> tvalid, busy and done go to 0 asynchronously; no beats after release until a new start edge.
